// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fully associative branch history table with saturating counters
// Optional BPU_STATIC_BTFN_EN: misses on conditional branches predict backward-taken/forward-not-taken.
module branch_predictor #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         lookup_valid_i,
    input  logic [ADDR_W-1:0]            lookup_pc_i,
    input  logic [31:0]                  lookup_inst_i,
    output logic                         pred_taken_o,
    output logic [ADDR_W-1:0]            pred_target_o,
    output logic                         pred_hit_o,
    input  logic                         upd_valid_i,
    input  logic [ADDR_W-1:0]            upd_pc_i,
    input  logic                         upd_taken_i,
    output logic [$clog2(ENTRIES):0]     occupancy_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENTRIES-1:0] valid;
    logic [ADDR_W-1:0]  tag [ENTRIES];
    logic [CNT_W-1:0]   cnt [ENTRIES];
    logic [IDX_W-1:0]   ptr;

    logic               is_branch;
    logic [12:0]        imm13;
    logic [ADDR_W-1:0]  imm_b;
    logic               lk_hit;
    logic [IDX_W-1:0]   lk_idx;
    logic               up_hit;
    logic [IDX_W-1:0]   up_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   alloc_idx;

    assign is_branch = lookup_valid_i && (lookup_inst_i[6:0] == 7'b1100011);
    assign imm13     = {lookup_inst_i[31], lookup_inst_i[7], lookup_inst_i[30:25],
                        lookup_inst_i[11:8], 1'b0};
    assign imm_b     = {{(ADDR_W-13){imm13[12]}}, imm13};

    // Searching from the top down leaves the lowest matching index as the winner.
    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        up_hit     = 1'b0;
        up_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tag[i] == lookup_pc_i)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid[i] && (tag[i] == upd_pc_i)) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_idx  = free_found ? free_idx : ptr;
    assign pred_hit_o = is_branch && lk_hit;

    always_comb begin
        pred_taken_o = 1'b0;
        if (pred_hit_o) begin
            pred_taken_o = cnt[lk_idx][CNT_W-1];
        end else if (is_branch) begin
`ifdef BPU_STATIC_BTFN_EN
            pred_taken_o = imm13[12];
`else
            pred_taken_o = 1'b0;
`endif
        end
    end

    assign pred_target_o = pred_taken_o ? (lookup_pc_i + imm_b) : (lookup_pc_i + ADDR_W'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            ptr         <= '0;
            occupancy_o <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt[i] <= WEAK_NT;
            end
        end else if (flush_i) begin
            valid       <= '0;
            ptr         <= '0;
            occupancy_o <= '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i && (cnt[up_idx] != CNT_MAX)) begin
                    cnt[up_idx] <= cnt[up_idx] + 1'b1;
                end else if (!upd_taken_i && (cnt[up_idx] != '0)) begin
                    cnt[up_idx] <= cnt[up_idx] - 1'b1;
                end
            end else begin
                valid[alloc_idx] <= 1'b1;
                tag[alloc_idx]   <= upd_pc_i;
                cnt[alloc_idx]   <= upd_taken_i ? WEAK_T : WEAK_NT;
                // One allocation per cycle, so filling a free slot is the only way occupancy grows.
                if (free_found) begin
                    occupancy_o <= occupancy_o + 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    localparam logic [31:0] BEQ_M8 = 32'hFE000CE3;
    localparam logic [31:0] BEQ_P8 = 32'h00000463;
    localparam logic [31:0] ADDI   = 32'h00000013;
`ifdef BPU_STATIC_BTFN_EN
    localparam logic [31:0] MISS_TGT   = 32'h000000F8;
    localparam logic        MISS_TAKEN = 1'b1;
`else
    localparam logic [31:0] MISS_TGT   = 32'h00000104;
    localparam logic        MISS_TAKEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_pc_i = '0;
    logic [31:0] lookup_inst_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        pred_hit_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [2:0]  occupancy_o;

    int total = 0;
    int bad = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i), .lookup_inst_i(lookup_inst_i),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o), .pred_hit_o(pred_hit_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic [31:0] inst);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc;
        lookup_inst_i  = inst;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_taken_i = tk;
        tick();
        upd_valid_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_occ", 32'(occupancy_o), 32'd0);

        look(32'h100, BEQ_M8);
        chk("miss_hit", 32'(pred_hit_o), 32'd0);
        chk("miss_taken", 32'(pred_taken_o), 32'(MISS_TAKEN));
        chk("miss_target", pred_target_o, MISS_TGT);

        upd(32'h100, 1'b1);
        look(32'h100, BEQ_M8);
        chk("alloc_hit", 32'(pred_hit_o), 32'd1);
        chk("alloc_taken", 32'(pred_taken_o), 32'd1);
        chk("alloc_target", pred_target_o, 32'h0F8);
        chk("alloc_occ", 32'(occupancy_o), 32'd1);

        upd(32'h100, 1'b0);
        upd(32'h100, 1'b0);
        look(32'h100, BEQ_M8);
        chk("nt2_taken", 32'(pred_taken_o), 32'd0);
        chk("nt2_target", pred_target_o, 32'h104);
        chk("nt2_hit", 32'(pred_hit_o), 32'd1);

        look(32'h100, ADDI);
        chk("addi_hit", 32'(pred_hit_o), 32'd0);
        chk("addi_target", pred_target_o, 32'h104);
        lookup_valid_i = 1'b0;
        #1;
        chk("novalid_hit", 32'(pred_hit_o), 32'd0);

        // Saturation: 2 -> 3 -> 3 -> 3, then 2 (taken), then 1 (not taken).
        upd(32'h300, 1'b1);
        upd(32'h300, 1'b1);
        upd(32'h300, 1'b1);
        upd(32'h300, 1'b1);
        look(32'h300, BEQ_M8);
        chk("sat_taken", 32'(pred_taken_o), 32'd1);
        upd(32'h300, 1'b0);
        look(32'h300, BEQ_M8);
        chk("sat_nt1_taken", 32'(pred_taken_o), 32'd1);
        upd(32'h300, 1'b0);
        look(32'h300, BEQ_M8);
        chk("sat_nt2_taken", 32'(pred_taken_o), 32'd0);
        chk("occ_two", 32'(occupancy_o), 32'd2);

        // Same-cycle lookup sees pre-update counter.
        upd_valid_i = 1'b1;
        upd_pc_i    = 32'h300;
        upd_taken_i = 1'b1;
        #1;
        chk("bypass_pre", 32'(pred_taken_o), 32'd0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("bypass_post", 32'(pred_taken_o), 32'd1);

        // Flush drops the same-cycle update.
        flush_i = 1'b1;
        upd(32'h200, 1'b1);
        flush_i = 1'b0;
        chk("flush_occ", 32'(occupancy_o), 32'd0);
        look(32'h100, BEQ_M8);
        chk("flush_100", 32'(pred_hit_o), 32'd0);
        look(32'h200, BEQ_M8);
        chk("flush_200", 32'(pred_hit_o), 32'd0);
        look(32'h300, BEQ_M8);
        chk("flush_300", 32'(pred_hit_o), 32'd0);

        // Round-robin replacement.
        upd(32'h10, 1'b1);
        upd(32'h20, 1'b1);
        upd(32'h30, 1'b1);
        upd(32'h40, 1'b1);
        chk("full_occ", 32'(occupancy_o), 32'd4);
        upd(32'h50, 1'b1);
        look(32'h10, BEQ_M8);
        chk("evict_10", 32'(pred_hit_o), 32'd0);
        look(32'h50, BEQ_M8);
        chk("keep_50", 32'(pred_hit_o), 32'd1);
        look(32'h20, BEQ_M8);
        chk("keep_20", 32'(pred_hit_o), 32'd1);
        upd(32'h60, 1'b1);
        look(32'h20, BEQ_M8);
        chk("evict_20", 32'(pred_hit_o), 32'd0);
        look(32'h30, BEQ_M8);
        chk("keep_30", 32'(pred_hit_o), 32'd1);
        look(32'h60, BEQ_M8);
        chk("keep_60", 32'(pred_hit_o), 32'd1);
        chk("evict_occ", 32'(occupancy_o), 32'd4);

        // Reset discards a same-cycle update.
        rst = 1'b1;
        upd(32'h500, 1'b1);
        rst = 1'b0;
        chk("rst_occ", 32'(occupancy_o), 32'd0);
        look(32'h500, BEQ_M8);
        chk("rst_drop", 32'(pred_hit_o), 32'd0);

        // Target wraps modulo 2^32.
        upd(32'hFFFFFFFC, 1'b1);
        look(32'hFFFFFFFC, BEQ_P8);
        chk("wrap_taken", 32'(pred_taken_o), 32'd1);
        chk("wrap_target", pred_target_o, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
